// File: rtl/scr1_tb_ahb_exit_monitor_if.sv
// Data-side AHB-Lite signal bundle between the core and its memory model.
// The monitor modport is a read-only tap for passive observers.
interface scr1_tb_ahb_exit_monitor_if;
   logic [1:0]  htrans;
   logic [31:0] haddr;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [31:0] hwdata;
   logic        hready;
   logic        hresp;

   modport master (
      output htrans, haddr, hwrite, hsize, hwdata,
      input  hready, hresp
   );

   modport slave (
      input  htrans, haddr, hwrite, hsize, hwdata,
      output hready, hresp
   );

   modport monitor (
      input htrans, haddr, hwrite, hsize, hwdata, hready, hresp
   );
endinterface

// File: rtl/scr1_tb_ahb_exit_monitor.sv
// Passive dmem snooper: latches the tohost exit word, counts RUN cycles, reports status.
// Define SCR1_TB_EXIT_WDOG_EN to add a watchdog that ends a test after TIMEOUT_CYCLES.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | after reset, no test started yet
// ST_RUN     | test running, cycles counted, exit write watched for
// ST_DONE    | exit write captured; status sticky until the next start
// ST_TIMEOUT | watchdog expired before any exit write
module scr1_tb_ahb_exit_monitor #(
   parameter logic [31:0] TOHOST_ADDR    = 32'hF000_0000,
   parameter int          CYCLE_CNT_W    = 32,
   parameter int          TIMEOUT_CYCLES = 1_000_000
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           start_i,
   scr1_tb_ahb_exit_monitor_if.monitor    dmem,
   output logic                           test_done_o,
   output logic                           test_pass_o,
   output logic                           test_timeout_o,
   output logic                           done_pulse_o,
   output logic [31:0]                    exit_code_o,
   output logic [CYCLE_CNT_W-1:0]         cycle_count_o
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_DONE    = 2'd2,
      ST_TIMEOUT = 2'd3
   } state_e;

   state_e                 state_q, state_d;
   logic                   pending_q, pending_d;
   logic                   done_q, done_d;
   logic                   pass_q, pass_d;
   logic                   pulse_q, pulse_d;
   logic [31:0]            code_q, code_d;
   logic [CYCLE_CNT_W-1:0] cnt_q, cnt_d;

   logic addr_active;
   logic exit_addr;
   logic wr_cmpl;
   logic cnt_sat;

   assign addr_active = ((dmem.htrans == 2'b10) || (dmem.htrans == 2'b11)) && dmem.hready;
   assign exit_addr   = addr_active && dmem.hwrite && (dmem.haddr == TOHOST_ADDR)
                        && (dmem.hsize == 3'b010);
   assign wr_cmpl     = pending_q && dmem.hready && !dmem.hresp;
   assign cnt_sat     = &cnt_q;

`ifdef SCR1_TB_EXIT_WDOG_EN
   logic tmo_q, tmo_d;
   logic wdog_hit;

   assign wdog_hit       = (cnt_q == CYCLE_CNT_W'(TIMEOUT_CYCLES - 1));
   assign test_timeout_o = tmo_q;
`else
   logic unused_tmo_cfg;

   assign unused_tmo_cfg = (TIMEOUT_CYCLES == 0);
   assign test_timeout_o = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      // Any completed address phase replaces the pending flag; a stalled bus keeps it.
      pending_d = dmem.hready ? exit_addr : pending_q;
      done_d    = done_q;
      pass_d    = pass_q;
      pulse_d   = 1'b0;
      code_d    = code_q;
      cnt_d     = cnt_q;
`ifdef SCR1_TB_EXIT_WDOG_EN
      tmo_d     = tmo_q;
`endif

      if (start_i) begin
         // start outranks a write completing on the same edge
         state_d   = ST_RUN;
         pending_d = 1'b0;
         done_d    = 1'b0;
         pass_d    = 1'b0;
         code_d    = 32'h0;
         cnt_d     = '0;
`ifdef SCR1_TB_EXIT_WDOG_EN
         tmo_d     = 1'b0;
`endif
      end else begin
         case (state_q)
            ST_RUN: begin
               if (!cnt_sat) begin
                  cnt_d = cnt_q + CYCLE_CNT_W'(1);
               end
               if (wr_cmpl) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
                  pass_d  = (dmem.hwdata == 32'h1);
                  code_d  = dmem.hwdata;
                  pulse_d = 1'b1;
               end
`ifdef SCR1_TB_EXIT_WDOG_EN
               else if (wdog_hit) begin
                  state_d = ST_TIMEOUT;
                  done_d  = 1'b1;
                  pass_d  = 1'b0;
                  tmo_d   = 1'b1;
                  pulse_d = 1'b1;
               end
`endif
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         pending_q <= 1'b0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
         pulse_q   <= 1'b0;
         code_q    <= 32'h0;
         cnt_q     <= '0;
`ifdef SCR1_TB_EXIT_WDOG_EN
         tmo_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         done_q    <= done_d;
         pass_q    <= pass_d;
         pulse_q   <= pulse_d;
         code_q    <= code_d;
         cnt_q     <= cnt_d;
`ifdef SCR1_TB_EXIT_WDOG_EN
         tmo_q     <= tmo_d;
`endif
      end
   end

   assign test_done_o   = done_q;
   assign test_pass_o   = pass_q;
   assign done_pulse_o  = pulse_q;
   assign exit_code_o   = code_q;
   assign cycle_count_o = cnt_q;

endmodule
